// File: rtl/mdu_pkg.sv
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared definitions for the multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam int MDU_PAR      = 32;
  localparam int OPCODE_W     = 3;
  localparam int DIV_CNT_W    = $clog2(MDU_PAR + 1);

  localparam logic [OPCODE_W-1:0] OP_DIV  = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_DIVU = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_REM  = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_sign_fix.sv
// ============================================================================
// Module : div_sign_fix
// Brief  : Conditional two's complement negation of a WIDTH-bit value.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_PAR
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] fixed
);

  assign fixed = negate ? (~value + WIDTH'(1)) : value;

endmodule

`default_nettype wire

// File: rtl/div_iter_core.sv
// ============================================================================
// Module : div_iter_core
// Brief  : Iterative radix-2 restoring divider, one quotient bit per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_iter_core
  import mdu_pkg::*;
#(
  parameter int PAR          = 32,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    flush,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  input  logic [PAR:0]            dividend,
  input  logic [PAR:0]            divisor,
  output logic                    busy,
  output logic                    done,
  output logic [PAR-1:0]          result
);

  localparam int CNT_W = $clog2(PAR + 1);

  div_state_t       r_state;
  div_state_t       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [PAR:0]     r_rem;
  logic [PAR-1:0]   r_quot;
  logic [PAR-1:0]   r_divMag;
  logic             r_qNeg;
  logic             r_rNeg;
  logic             r_div0;
  logic             r_selRem;
  logic [PAR-1:0]   r_result;

  logic [PAR-1:0]   w_dvdMag;
  logic [PAR-1:0]   w_dvsMag;
  logic [PAR:0]     w_shift;
  logic [PAR+1:0]   w_trial;
  logic             w_ge;
  logic             w_accept;
  logic [PAR-1:0]   w_fixIn;
  logic             w_fixNeg;
  logic [PAR-1:0]   w_fixed;
  logic             w_unused;

  div_sign_fix #(.WIDTH(PAR)) u_dvdMag (
    .value  (dividend[PAR-1:0]),
    .negate (dividend[PAR]),
    .fixed  (w_dvdMag)
  );

  div_sign_fix #(.WIDTH(PAR)) u_dvsMag (
    .value  (divisor[PAR-1:0]),
    .negate (divisor[PAR]),
    .fixed  (w_dvsMag)
  );

  // Only the selected result is needed, so one negator serves both quotient and remainder.
  // A zero divisor makes every trial succeed, leaving the quotient all ones and the
  // remainder equal to |dividend|; suppressing quotient negation yields the required values.
  assign w_fixIn  = r_selRem ? r_rem[PAR-1:0] : r_quot;
  assign w_fixNeg = r_selRem ? r_rNeg : (r_qNeg & ~r_div0);

  div_sign_fix #(.WIDTH(PAR)) u_resFix (
    .value  (w_fixIn),
    .negate (w_fixNeg),
    .fixed  (w_fixed)
  );

  assign w_shift  = {r_rem[PAR-1:0], r_quot[PAR-1]};
  assign w_trial  = {1'b0, w_shift} - {2'b00, r_divMag};
  assign w_ge     = ~w_trial[PAR+1];
  assign w_accept = start & ~flush & ((r_state == IDLE) | (r_state == DONE));
  assign w_unused = ^{opCode[OPCODE_WIDTH-1:2], opCode[0], r_rem[PAR]};

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: w_nextState = w_accept ? CALC : IDLE;
      CALC: begin
        if (flush)                     w_nextState = IDLE;
        else if (r_cnt == CNT_W'(1))   w_nextState = FIX;
        else                           w_nextState = CALC;
      end
      FIX:        w_nextState = flush ? IDLE : DONE;
      default:    w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_divMag <= '0;
      r_qNeg   <= 1'b0;
      r_rNeg   <= 1'b0;
      r_div0   <= 1'b0;
      r_selRem <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_cnt    <= CNT_W'(PAR);
        r_rem    <= '0;
        r_quot   <= w_dvdMag;
        r_divMag <= w_dvsMag;
        r_qNeg   <= dividend[PAR] ^ divisor[PAR];
        r_rNeg   <= dividend[PAR];
        r_div0   <= (divisor == '0);
        r_selRem <= opCode[1];
      end else if (r_state == CALC && !flush) begin
        r_cnt  <= r_cnt - CNT_W'(1);
        r_rem  <= w_ge ? w_trial[PAR:0] : w_shift;
        r_quot <= {r_quot[PAR-2:0], w_ge};
      end else if (r_state == FIX && !flush) begin
        r_result <= w_fixed;
      end
    end
  end

  assign busy   = (r_state == CALC) | (r_state == FIX);
  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_div_iter_core.sv
// ============================================================================
// Module : tb_div_iter_core
// Brief  : Self-checking bench for div_iter_core against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_iter_core;

  localparam int PAR = 32;
  localparam int LAT = PAR + 2;

  localparam logic [2:0] C_DIV  = 3'b100;
  localparam logic [2:0] C_DIVU = 3'b101;
  localparam logic [2:0] C_REM  = 3'b110;
  localparam logic [2:0] C_REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      opCode = 3'b000;
  logic [PAR:0]    dividend = '0;
  logic [PAR:0]    divisor = '0;
  logic            busy;
  logic            done;
  logic [PAR-1:0]  result;

  int cyc = 0;
  int accCyc = 0;
  int total = 0;
  int passed = 0;
  int failed = 0;

  div_iter_core #(.PAR(PAR), .OPCODE_WIDTH(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .flush    (flush),
    .opCode   (opCode),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: signed arithmetic on the 33-bit operands, divide-by-zero rules applied.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [32:0] a,
                                        input logic [32:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = -1;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives start from a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [2:0] op, input logic [32:0] a, input logic [32:0] b);
    opCode   = op;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    accCyc   = cyc;
    start    = 1'b0;
    opCode   = 3'($urandom);
    dividend = {1'b0, 32'($urandom)};
    divisor  = {1'b0, 32'($urandom)};
  endtask

  // lat is the rising edge (relative to the accepting one) that samples done high.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - accCyc + 1;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [32:0] a,
                       input logic [32:0] b);
    int lat;
    launch(op, a, b);
    waitDone(lat);
    chk({tag, " latency"}, 64'(lat), 64'(LAT));
    chk({tag, " result"}, 64'(result), 64'(model(op, a, b)));
  endtask

  function automatic logic [32:0] sx(input logic [31:0] v);
    return {v[31], v};
  endfunction

  initial begin
    int lat;
    int pulses;
    logic [31:0] prevRes;
    logic [2:0]  op;
    logic [32:0] a, b;
    logic [31:0] x;

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset result", 64'(result), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic unsigned, plus single-cycle done pulse
    launch(C_DIVU, 33'd100, 33'd7);
    chk("divu busy", 64'(busy), 64'(1));
    waitDone(lat);
    chk("divu 100/7 latency", 64'(lat), 64'(LAT));
    chk("divu 100/7 result", 64'(result), 64'(14));
    chk("divu busy in done", 64'(busy), 64'(0));
    @(negedge clk);
    chk("done pulse width", 64'(done), 64'(0));
    runOp("remu 100/7", C_REMU, 33'd100, 33'd7);
    chk("remu 100/7 const", 64'(result), 64'(2));

    runOp("div -7/2", C_DIV, sx(-32'sd7), sx(32'sd2));
    chk("div -7/2 const", 64'(result), 64'(32'hFFFF_FFFD));
    runOp("rem -7/2", C_REM, sx(-32'sd7), sx(32'sd2));
    chk("rem -7/2 const", 64'(result), 64'(32'hFFFF_FFFF));

    runOp("div 5/0", C_DIV, 33'd5, 33'd0);
    chk("div 5/0 const", 64'(result), 64'(32'hFFFF_FFFF));
    runOp("remu 5/0", C_REMU, 33'd5, 33'd0);
    chk("remu 5/0 const", 64'(result), 64'(5));
    runOp("div -5/0", C_DIV, sx(-32'sd5), 33'd0);
    runOp("rem -5/0", C_REM, sx(-32'sd5), 33'd0);

    runOp("div ovf", C_DIV, sx(32'h8000_0000), sx(32'hFFFF_FFFF));
    chk("div ovf const", 64'(result), 64'(32'h8000_0000));
    runOp("rem ovf", C_REM, sx(32'h8000_0000), sx(32'hFFFF_FFFF));
    chk("rem ovf const", 64'(result), 64'(0));

    // start while busy is ignored and operands are not re-sampled
    launch(C_DIVU, 33'd100, 33'd7);
    repeat (9) @(negedge clk);
    start = 1'b1; opCode = C_REMU; dividend = 33'd999; divisor = 33'd10;
    @(negedge clk);
    start = 1'b0;
    chk("ignored start busy", 64'(busy), 64'(1));
    waitDone(lat);
    chk("ignored start latency", 64'(lat), 64'(LAT));
    chk("ignored start result", 64'(result), 64'(14));

    // flush mid-CALC
    prevRes = result;
    launch(C_DIVU, 33'd1000, 33'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'(0));
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done) pulses++; end
    chk("flush no done", 64'(pulses), 64'(0));
    chk("flush result held", 64'(result), 64'(prevRes));

    // start in the DONE cycle
    launch(C_DIVU, 33'd1000, 33'd3);
    waitDone(lat);
    chk("b2b first result", 64'(result), 64'(333));
    launch(C_REMU, 33'd1000, 33'd3);
    chk("b2b accept busy", 64'(busy), 64'(1));
    waitDone(lat);
    chk("b2b second latency", 64'(lat), 64'(LAT));
    chk("b2b second result", 64'(result), 64'(1));

    // flush and start together: start dropped
    @(negedge clk);
    prevRes = result;
    start = 1'b1; flush = 1'b1; opCode = C_DIVU; dividend = 33'd50; divisor = 33'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy", 64'(busy), 64'(0));
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done) pulses++; end
    chk("flush+start no done", 64'(pulses), 64'(0));
    chk("flush+start result", 64'(result), 64'(prevRes));

    // asynchronous reset mid-CALC
    launch(C_DIVU, 33'd1000, 33'd3);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'(0));
    chk("async rst done", 64'(done), 64'(0));
    chk("async rst result", 64'(result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runOp("divu max/1", C_DIVU, {1'b0, 32'hFFFF_FFFF}, 33'd1);
    chk("divu max/1 const", 64'(result), 64'(32'hFFFF_FFFF));

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      op = 3'b100 | 3'($urandom_range(0, 3));
      x  = $urandom;
      a  = op[0] ? {1'b0, x} : sx(x);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2, 3: begin
          b = 33'($urandom_range(1, 20));
          if (!op[0] && $urandom_range(0, 1) == 1) b = -b;
        end
        default: begin
          x = $urandom;
          b = op[0] ? {1'b0, x} : sx(x);
        end
      endcase
      runOp($sformatf("rand%0d op%0b", i, op), op, a, b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
